// File: rtl/selector_pkg.sv
// Shared definitions for the tic-tac-toe style board selector.
// Holds the 2-bit cell codes and the game-state enumeration used by
// selector_tablero.
package selector_pkg;

  localparam logic [1:0] VACIA = 2'b00;
  localparam logic [1:0] JUG1  = 2'b11;
  localparam logic [1:0] JUG2  = 2'b01;

  typedef enum logic [1:0] {
    JUGANDO   = 2'd0,
    LLENO     = 2'd1,
    TERMINADO = 2'd2
  } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for one debounced, clk-synchronous button level.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   clear    - synchronous clear of the history register (new game)
//   boton    - button level
//   flanco_c - combinational pulse, high on the first high sample
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic boton,
  output logic flanco_c
);

  logic previo;

  // One-register history of the button level
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      previo <= 1'b0;
    end else begin
      previo <= boton;
    end
  end

  assign flanco_c = boton & ~previo;

endmodule

// File: rtl/selector_tablero.sv
// Cursor / board / turn controller for an N x N two-player board game.
// Buttons are edge detected; at most one action per cycle with priority
// nuevo_juego > fin_juego > elige > arriba > abajo > izq > der.
// Optional feature macro: CURSOR_WRAP_EN (cursor wraps within its row or
// column instead of saturating at the board edges).
// Ports:
//   clk, reset                       - clock and synchronous active-high reset
//   boton_arriba/abajo/izq/der/elige - debounced button levels
//   nuevo_juego                      - start a new game
//   fin_juego                        - winner detected level
//   cuadro                           - cursor cell, 1-based, row 0 at bottom
//   tablero                          - board, cell i at bits [2i+1:2i]
//   turno_p1/turno_p2                - player to move (one-hot)
//   p1_mm/p2_mm                      - last player that moved
//   jugada_valida/jugada_invalida    - one-cycle move result pulses
//   jugadas                          - stored move count
//   tablero_lleno                    - all cells occupied
module selector_tablero
  import selector_pkg::*;
#(
  parameter  int unsigned N  = 3,
  localparam int unsigned CW = $clog2(N*N+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            boton_arriba,
  input  logic            boton_abajo,
  input  logic            boton_izq,
  input  logic            boton_der,
  input  logic            boton_elige,
  input  logic            nuevo_juego,
  input  logic            fin_juego,
  output logic [CW-1:0]   cuadro,
  output logic [2*N*N-1:0] tablero,
  output logic            turno_p1,
  output logic            turno_p2,
  output logic            p1_mm,
  output logic            p2_mm,
  output logic            jugada_valida,
  output logic            jugada_invalida,
  output logic [CW-1:0]   jugadas,
  output logic            tablero_lleno
);

  localparam int unsigned NC         = N*N;
  localparam int unsigned RW         = $clog2(N);
  localparam int unsigned CENTRO_I   = N/2;
  localparam int unsigned CUADRO_I   = CENTRO_I*N + CENTRO_I + 1;
  localparam logic [RW-1:0] CENTRO   = RW'(CENTRO_I);
  localparam logic [RW-1:0] ULTIMA   = RW'(N-1);
  localparam logic [CW-1:0] CUADRO_0 = CW'(CUADRO_I);
  localparam logic [CW-1:0] TOTAL    = CW'(NC);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic arriba_c, abajo_c, izq_c, der_c, elige_c;

  detector_flanco u_fl_arriba (
    .clk(clk), .reset(reset), .clear(nuevo_juego), .boton(boton_arriba), .flanco_c(arriba_c)
  );
  detector_flanco u_fl_abajo (
    .clk(clk), .reset(reset), .clear(nuevo_juego), .boton(boton_abajo), .flanco_c(abajo_c)
  );
  detector_flanco u_fl_izq (
    .clk(clk), .reset(reset), .clear(nuevo_juego), .boton(boton_izq), .flanco_c(izq_c)
  );
  detector_flanco u_fl_der (
    .clk(clk), .reset(reset), .clear(nuevo_juego), .boton(boton_der), .flanco_c(der_c)
  );
  detector_flanco u_fl_elige (
    .clk(clk), .reset(reset), .clear(nuevo_juego), .boton(boton_elige), .flanco_c(elige_c)
  );

  estado_t         estado_q, estado_d;
  logic [RW-1:0]   row_q, row_d, col_q, col_d;
  logic [CW-1:0]   cuadro_d, jugadas_d, idx_c;
  logic [2*NC-1:0] tablero_d, mascara_c;
  logic [NC-1:0]   sel_c, ocup_c;
  logic [1:0]      codigo_c;
  logic            turno_d, p1_mm_d, p2_mm_d, valida_d, invalida_d;
  logic            ocupada_c;

  // 0-based index of the cell under the cursor
  assign idx_c = CW'(row_q) * CW'(N) + CW'(col_q);

  // Per-cell select, write mask and occupancy
  for (genvar g = 0; g < NC; g++) begin : g_celda
    assign sel_c[g]             = (idx_c == CW'(g));
    assign mascara_c[2*g +: 2]  = {2{sel_c[g]}};
    assign ocup_c[g]            = |tablero[2*g +: 2];
  end

  assign ocupada_c = |(sel_c & ocup_c);
  assign codigo_c  = turno_p1 ? JUG1 : JUG2;

  // Next-state: one prioritised action per cycle
  always_comb begin
    estado_d   = estado_q;
    row_d      = row_q;
    col_d      = col_q;
    tablero_d  = tablero;
    turno_d    = turno_p1;
    p1_mm_d    = p1_mm;
    p2_mm_d    = p2_mm;
    valida_d   = 1'b0;
    invalida_d = 1'b0;
    jugadas_d  = jugadas;

    if (nuevo_juego) begin
      estado_d  = JUGANDO;
      row_d     = CENTRO;
      col_d     = CENTRO;
      tablero_d = '0;
      turno_d   = 1'b1;
      p1_mm_d   = 1'b0;
      p2_mm_d   = 1'b0;
      jugadas_d = '0;
    end else if (fin_juego) begin
      // fin_juego consumes the cycle in every state; only play ends
      if (estado_q == JUGANDO) begin
        estado_d = TERMINADO;
      end
    end else if (elige_c) begin
      if (estado_q == JUGANDO) begin
        if (ocupada_c) begin
          invalida_d = 1'b1;
        end else begin
          tablero_d = (tablero & ~mascara_c) | ({NC{codigo_c}} & mascara_c);
          jugadas_d = jugadas + CW'(1);
          valida_d  = 1'b1;
          p1_mm_d   = turno_p1;
          p2_mm_d   = ~turno_p1;
          turno_d   = ~turno_p1;
          if (jugadas_d == TOTAL) begin
            estado_d = LLENO;
          end
        end
      end
    end else if (arriba_c) begin
      if (row_q != ULTIMA) begin
        row_d = row_q + RW'(1);
      end else if (WRAP) begin
        row_d = '0;
      end
    end else if (abajo_c) begin
      if (row_q != '0) begin
        row_d = row_q - RW'(1);
      end else if (WRAP) begin
        row_d = ULTIMA;
      end
    end else if (izq_c) begin
      if (col_q != '0) begin
        col_d = col_q - RW'(1);
      end else if (WRAP) begin
        col_d = ULTIMA;
      end
    end else if (der_c) begin
      if (col_q != ULTIMA) begin
        col_d = col_q + RW'(1);
      end else if (WRAP) begin
        col_d = '0;
      end
    end

    cuadro_d = CW'(row_d) * CW'(N) + CW'(col_d) + CW'(1);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q        <= JUGANDO;
      row_q           <= CENTRO;
      col_q           <= CENTRO;
      cuadro          <= CUADRO_0;
      tablero         <= '0;
      turno_p1        <= 1'b1;
      turno_p2        <= 1'b0;
      p1_mm           <= 1'b0;
      p2_mm           <= 1'b0;
      jugada_valida   <= 1'b0;
      jugada_invalida <= 1'b0;
      jugadas         <= '0;
      tablero_lleno   <= 1'b0;
    end else begin
      estado_q        <= estado_d;
      row_q           <= row_d;
      col_q           <= col_d;
      cuadro          <= cuadro_d;
      tablero         <= tablero_d;
      turno_p1        <= turno_d;
      turno_p2        <= ~turno_d;
      p1_mm           <= p1_mm_d;
      p2_mm           <= p2_mm_d;
      jugada_valida   <= valida_d;
      jugada_invalida <= invalida_d;
      jugadas         <= jugadas_d;
      tablero_lleno   <= (jugadas_d == TOTAL);
    end
  end

endmodule

// File: tb/tb_selector_tablero.sv
// Scoreboard bench for selector_tablero: an N=3 instance carries the game
// scenarios, an N=4 instance checks the reset cursor and bottom-edge moves.
module tb_selector_tablero;
  import selector_pkg::*;

  localparam logic [7:0] M_DER    = 8'h01;
  localparam logic [7:0] M_IZQ    = 8'h02;
  localparam logic [7:0] M_ABAJO  = 8'h04;
  localparam logic [7:0] M_ARRIBA = 8'h08;
  localparam logic [7:0] M_ELIGE  = 8'h10;
  localparam logic [7:0] M_FIN    = 8'h20;
  localparam logic [7:0] M_NUEVO  = 8'h40;
  localparam logic [7:0] M_ABAJO4 = 8'h80;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arriba, abajo, izq, der, elige, nuevo, fin, abajo4;

  logic [3:0]  cuadro, jugadas;
  logic [17:0] tablero;
  logic        turno_p1, turno_p2, p1_mm, p2_mm, valida, invalida, lleno;

  logic [4:0]  cuadro4, jugadas4;
  logic [31:0] tablero4;
  logic        t1_4, t2_4, m1_4, m2_4, v_4, inv_4, lleno4;

  typedef struct {
    int          step;
    logic [3:0]  cuadro;
    logic [17:0] tab;
    logic        t1, t2, m1, m2, v, inv, lleno;
    logic [3:0]  jug;
    estado_t     st;
    logic [4:0]  cuadro4;
  } snap_t;

  snap_t e;
  snap_t q[$];
  int    paso   = 0;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  selector_tablero #(.N(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .boton_arriba(arriba), .boton_abajo(abajo), .boton_izq(izq),
    .boton_der(der), .boton_elige(elige),
    .nuevo_juego(nuevo), .fin_juego(fin),
    .cuadro(cuadro), .tablero(tablero),
    .turno_p1(turno_p1), .turno_p2(turno_p2),
    .p1_mm(p1_mm), .p2_mm(p2_mm),
    .jugada_valida(valida), .jugada_invalida(invalida),
    .jugadas(jugadas), .tablero_lleno(lleno)
  );

  selector_tablero #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .boton_arriba(1'b0), .boton_abajo(abajo4), .boton_izq(1'b0),
    .boton_der(1'b0), .boton_elige(1'b0),
    .nuevo_juego(1'b0), .fin_juego(1'b0),
    .cuadro(cuadro4), .tablero(tablero4),
    .turno_p1(t1_4), .turno_p2(t2_4),
    .p1_mm(m1_4), .p2_mm(m2_4),
    .jugada_valida(v_4), .jugada_invalida(inv_4),
    .jugadas(jugadas4), .tablero_lleno(lleno4)
  );

  task automatic chk(input int stp, input string nom, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL step %0d %s: got %0h expected %0h", stp, nom, got, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation, compare all outputs
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        s = q.pop_front();
        chk(s.step, "cuadro",          32'(cuadro),          32'(s.cuadro));
        chk(s.step, "tablero",         32'(tablero),         32'(s.tab));
        chk(s.step, "turno_p1",        32'(turno_p1),        32'(s.t1));
        chk(s.step, "turno_p2",        32'(turno_p2),        32'(s.t2));
        chk(s.step, "p1_mm",           32'(p1_mm),           32'(s.m1));
        chk(s.step, "p2_mm",           32'(p2_mm),           32'(s.m2));
        chk(s.step, "jugada_valida",   32'(valida),          32'(s.v));
        chk(s.step, "jugada_invalida", 32'(invalida),        32'(s.inv));
        chk(s.step, "jugadas",         32'(jugadas),         32'(s.jug));
        chk(s.step, "tablero_lleno",   32'(lleno),           32'(s.lleno));
        chk(s.step, "estado",          32'(u_dut3.estado_q), 32'(s.st));
        chk(s.step, "cuadro_n4",       32'(cuadro4),         32'(s.cuadro4));
      end
    end
  end

  task automatic push();
    snap_t s;
    s      = e;
    s.step = paso;
    paso++;
    q.push_back(s);
  endtask

  task automatic drive(input logic [7:0] m);
    der    = m[0];
    izq    = m[1];
    abajo  = m[2];
    arriba = m[3];
    elige  = m[4];
    fin    = m[5];
    nuevo  = m[6];
    abajo4 = m[7];
  endtask

  // Hold inputs for 'hold' cycles, then release for one cycle
  task automatic accion(input logic [7:0] m, input int hold);
    @(negedge clk);
    drive(m);
    @(posedge clk);
    push();
    e.v   = 1'b0;
    e.inv = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk);
      push();
    end
    @(negedge clk);
    drive(8'h00);
    @(posedge clk);
    push();
  endtask

  task automatic e_reset();
    e.cuadro = 4'd5;
    e.tab    = '0;
    e.t1     = 1'b1;
    e.t2     = 1'b0;
    e.m1     = 1'b0;
    e.m2     = 1'b0;
    e.v      = 1'b0;
    e.inv    = 1'b0;
    e.jug    = 4'd0;
    e.lleno  = 1'b0;
    e.st     = JUGANDO;
  endtask

  // Expected effect of a valid move of 'cod' on cell 'celda' (0-based)
  task automatic jugar(input int celda, input logic [1:0] cod, input int n,
                       input logic [7:0] extra);
    e.tab = (e.tab & ~(18'h3 << (2*celda))) | ({16'h0, cod} << (2*celda));
    e.v   = 1'b1;
    e.m1  = (cod == JUG1);
    e.m2  = (cod == JUG2);
    e.t1  = (cod == JUG2);
    e.t2  = (cod == JUG1);
    e.jug = 4'(n);
    accion(M_ELIGE | extra, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] dirs [9];
    int         celdas [9];
    logic [3:0] cuadros [9];
    dirs    = '{8'h00, M_IZQ, M_ABAJO, M_DER, M_DER, M_ARRIBA, M_ARRIBA, M_IZQ, M_IZQ};
    celdas  = '{4, 3, 0, 1, 2, 5, 8, 7, 6};
    cuadros = '{4'd5, 4'd4, 4'd1, 4'd2, 4'd3, 4'd6, 4'd9, 4'd8, 4'd7};

    drive(8'h00);
    e_reset();
    e.cuadro4 = 5'd11;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    push();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    push();

    // Cursor moves then first move by player 1 on cell 8
    e.cuadro = 4'd6; accion(M_DER, 1);
    e.cuadro = 4'd9; accion(M_ARRIBA, 1);
    jugar(8, JUG1, 1, 8'h00);

    // New game, then a repeated press on the same cell
    e_reset(); accion(M_NUEVO, 1);
    jugar(4, JUG1, 1, 8'h00);
    e.inv = 1'b1; accion(M_ELIGE, 1);

    // Right edge behaviour at cuadro 9
    e.cuadro = 4'd8; accion(M_ARRIBA, 1);
    e.cuadro = 4'd9; accion(M_DER, 1);
`ifdef CURSOR_WRAP_EN
    e.cuadro = 4'd7;
`else
    e.cuadro = 4'd9;
`endif
    accion(M_DER, 1);

    // A held button acts only once
    e_reset(); accion(M_NUEVO, 1);
    e.cuadro = 4'd8; accion(M_ARRIBA, 3);

    // nuevo_juego discards a same-cycle move; elige beats arriba
    e_reset(); accion(M_NUEVO | M_DER, 1);
    jugar(4, JUG1, 1, M_ARRIBA);

    // Fill the whole board alternately
    e_reset(); accion(M_NUEVO, 1);
    for (int k = 0; k < 9; k++) begin
      if (dirs[k] != 8'h00) begin
        e.cuadro = cuadros[k];
        accion(dirs[k], 1);
      end
      if (k == 8) begin
        e.lleno = 1'b1;
        e.st    = LLENO;
      end
      jugar(celdas[k], (k % 2 == 0) ? JUG1 : JUG2, k + 1, 8'h00);
    end
    accion(M_ELIGE, 1);
    e.cuadro = 4'd8; accion(M_DER, 1);

    // fin_juego wins over a same-cycle elige
    e_reset(); accion(M_NUEVO, 1);
    jugar(4, JUG1, 1, 8'h00);
    e.cuadro = 4'd6; accion(M_DER, 1);
    e.st = TERMINADO; accion(M_FIN | M_ELIGE, 1);
    accion(M_ELIGE, 1);
    e.cuadro = 4'd5; accion(M_IZQ, 1);
    e_reset(); accion(M_NUEVO, 1);

    // N=4 instance: bottom edge from the centre cursor
    e.cuadro4 = 5'd7; accion(M_ABAJO4, 1);
    e.cuadro4 = 5'd3; accion(M_ABAJO4, 1);
`ifdef CURSOR_WRAP_EN
    e.cuadro4 = 5'd15;
`else
    e.cuadro4 = 5'd3;
`endif
    accion(M_ABAJO4, 1);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/selector_tablero.md
SELECTOR_TABLERO -- requirements
Module: selector_tablero

Interface
REQ-001 SHALL have parameter N, default 3, meaning board side length (board is N x N cells, N = 2..8).
REQ-002 SHALL have derived localparam CW = clog2(N*N+1), the width of the cell index.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports boton_arriba, boton_abajo, boton_izq, boton_der, boton_elige, input, 1 each, debounced, clk-synchronous button levels.
REQ-006 SHALL have port nuevo_juego, input, 1, synchronous start of a new game.
REQ-007 SHALL have port fin_juego, input, 1, a winner-detected level from the downstream checker.
REQ-008 SHALL have port cuadro, output, CW, the cursor cell, 1-based: row*N+col+1, with row 0 at the bottom.
REQ-009 SHALL have port tablero, output, 2*N*N, where cell i (0-based) is at bits [2i+1:2i].
REQ-010 SHALL have ports turno_p1 and turno_p2, output, 1 each, the one-hot player to move.
REQ-011 SHALL have ports p1_mm and p2_mm, output, 1 each, the one-hot last player to move (both 0 before the first move).
REQ-012 SHALL have ports jugada_valida and jugada_invalida, output, 1 each, one-cycle pulses.
REQ-013 SHALL have port jugadas, output, CW, the count of stored moves.
REQ-014 SHALL have port tablero_lleno, output, 1, high when jugadas equals N*N.

Function
REQ-015 Each button SHALL be rising-edge detected with one register; an action SHALL be visible on outputs one clk after the first high sample.
REQ-016 At most one action SHALL be taken per cycle, with priority nuevo_juego > fin_juego > elige > arriba > abajo > izq > der.
REQ-017 Arriba SHALL set row+1, abajo row-1, der col+1, izq col-1; an out-of-range move SHALL obey REQ-027.
REQ-018 Cell encoding SHALL be: 00 empty, 11 player 1, 01 player 2.
REQ-019 The FSM SHALL have states JUGANDO, LLENO and TERMINADO.
REQ-020 In JUGANDO, elige on an empty cell SHALL write the mover's code, increment jugadas, pulse jugada_valida, set p1_mm/p2_mm to the mover and toggle turno.
REQ-021 In JUGANDO, elige on an occupied cell SHALL leave the board, turn and count unchanged and pulse jugada_invalida.
REQ-022 The FSM SHALL go JUGANDO->LLENO when a valid move makes jugadas equal N*N.
REQ-023 The FSM SHALL go JUGANDO->TERMINADO while fin_juego is high; fin_juego SHALL win over a same-cycle elige, so no write occurs.
REQ-024 In LLENO and TERMINADO, cursor moves SHALL be allowed, and elige SHALL be ignored with no pulse.
REQ-025 nuevo_juego SHALL apply the reset values of REQ-026 from any state, and any same-cycle button SHALL be discarded.

Reset
REQ-026 Reset and nuevo_juego SHALL set:
- state JUGANDO
- tablero all 00
- cursor at the centre: row = col = N/2, so cuadro = 5 for N=3
- turno_p1=1, turno_p2=0
- p1_mm = p2_mm = 0
- jugadas 0
- both pulses 0
- edge registers cleared

Configuration
REQ-027 With CURSOR_WRAP_EN defined, the cursor SHALL wrap within its row or column (col N-1 + der -> col 0); undefined, it SHALL saturate at the edges (no change).

Structure
REQ-028 Package selector_pkg SHALL hold the cell codes (VACIA, JUG1, JUG2) and the FSM state enum.
REQ-029 The sub-module detector_flanco SHALL be instantiated once per button; cursor, board, FSM and counter stay in the top module.

Verification
REQ-030 The bench SHALL cover, for N=3:
- After reset, der then arriba -> cuadro 5, 6, 9; elige -> tablero cell 8 = 11, jugada_valida one cycle, turno_p2=1, p1_mm=1.
- elige twice on cuadro 5 -> 2nd press gives jugada_invalida, jugadas=1, turno unchanged.
- At cuadro 9, der: with CURSOR_WRAP_EN -> 7; without -> stays 9.
- Fill all 9 cells alternately -> jugadas=9, tablero_lleno=1, state LLENO; a further elige gives no pulse and no change.
- fin_juego and elige in the same cycle -> TERMINADO, board unchanged; then nuevo_juego -> board cleared, cuadro 5, turno_p1=1.
- N=4 build: reset -> cuadro 11; abajo x3 -> cuadro 3 when saturating.
